// File: rtl/pixel_filter_pkg.sv
// Shared parameters, credit-state encoding and sizing helper
// for the pixel output controller.
package pixel_filter_pkg;

    localparam int DEF_PIXEL_W     = 8;
    localparam int DEF_LINE_PIXELS = 512;
    localparam int DEF_NUM_LINES   = 512;
    localparam int DEF_FIFO_DEPTH  = 1024;

    typedef enum logic [1:0] {
        WAIT,
        GRANT,
        RECV
    } credit_state_t;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is
// visible on o_rd_data whenever o_empty is low.
module sync_fifo
    import pixel_filter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024,
    localparam int AW   = clog2_min1(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // A full FIFO still accepts a write when the head leaves this cycle.
    assign w_rd = i_rd_en & ~o_empty;
    assign w_wr = i_wr_en & (~o_full | w_rd);

    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
        end
    end

endmodule

// File: rtl/pixel_out_ctrl.sv
// Buffers line bursts of filtered pixels, grants line credits upstream
// and streams pixels downstream with line/frame markers and interrupts.
module pixel_out_ctrl
    import pixel_filter_pkg::*;
#(
    parameter int PIXEL_W     = DEF_PIXEL_W,
    parameter int LINE_PIXELS = DEF_LINE_PIXELS,
    parameter int NUM_LINES   = DEF_NUM_LINES,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    localparam int FILL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PIXEL_W-1:0] i_pixel_data,
    input  logic               i_pixel_data_valid,
    output logic               o_line_credit,
    output logic [PIXEL_W-1:0] o_m_data,
    output logic               o_m_valid,
    input  logic               i_m_ready,
    output logic               o_m_last,
    output logic               o_m_sof,
    output logic               o_intr,
    output logic               o_overflow,
    output logic [FILL_W-1:0]  o_fill
);

    localparam int PX_W = clog2_min1(LINE_PIXELS);
    localparam int LN_W = clog2_min1(NUM_LINES);
    localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(LINE_PIXELS - 1);
    localparam logic [LN_W-1:0]   LN_LAST   = LN_W'(NUM_LINES - 1);
    localparam logic [FILL_W-1:0] FILL_ROOM = FILL_W'(FIFO_DEPTH - LINE_PIXELS);

    credit_state_t   r_state;
    credit_state_t   w_state_nxt;
    logic [PX_W-1:0] r_in_cnt;
    logic [PX_W-1:0] w_in_cnt_nxt;
    logic [PX_W-1:0] r_out_px;
    logic [LN_W-1:0] r_out_line;
    logic            r_intr;
    logic            r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_rd;
    logic              w_wr;
    logic              w_px_last;
    logic [FILL_W-1:0] w_count;

    assign w_rd      = ~w_empty & i_m_ready;
    assign w_wr      = i_pixel_data_valid & (~w_full | w_rd);
    assign w_px_last = (r_out_px == PX_LAST);

    sync_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_pixel_data_valid),
        .i_wr_data (i_pixel_data),
        .i_rd_en   (i_m_ready),
        .o_rd_data (o_m_data),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign o_m_valid     = ~w_empty;
    assign o_fill        = w_count;
    assign o_line_credit = (r_state == GRANT);
    assign o_m_last      = o_m_valid & w_px_last;
    assign o_m_sof       = o_m_valid & (r_out_px == '0) & (r_out_line == '0);
    assign o_intr        = r_intr;
    assign o_overflow    = r_overflow;

    always_comb begin
        w_state_nxt  = r_state;
        w_in_cnt_nxt = r_in_cnt;
        unique case (r_state)
            WAIT: begin
                if (w_count <= FILL_ROOM)
                    w_state_nxt = GRANT;
            end
            GRANT: begin
                if (w_wr) begin
                    w_state_nxt  = RECV;
                    w_in_cnt_nxt = PX_W'(1);
                end
            end
            RECV: begin
                if (w_wr) begin
                    if (r_in_cnt == PX_LAST) begin
                        w_state_nxt  = WAIT;
                        w_in_cnt_nxt = '0;
                    end else begin
                        w_in_cnt_nxt = r_in_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt  = WAIT;
                w_in_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= WAIT;
            r_in_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_in_cnt <= w_in_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_px   <= '0;
            r_out_line <= '0;
            r_intr     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_intr     <= w_rd & w_px_last;
            r_overflow <= r_overflow | (i_pixel_data_valid & ~w_wr);
            if (w_rd) begin
                if (w_px_last) begin
                    r_out_px   <= '0;
                    r_out_line <= (r_out_line == LN_LAST) ? '0 : r_out_line + 1'b1;
                end else begin
                    r_out_px <= r_out_px + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_out_ctrl.sv
// Scoreboard bench: stimulus queues expected pixels and markers,
// a negedge monitor pops and compares them on every handshake.
module tb_pixel_out_ctrl;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       sof;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_v, a_rdy, a_cred, a_mv, a_last, a_sof, a_intr, a_ovf;
    logic [7:0]  a_d, a_md;
    logic [10:0] a_fill;
    logic        b_rst, b_v, b_rdy, b_cred, b_mv, b_last, b_sof, b_intr, b_ovf;
    logic [7:0]  b_d, b_md;
    logic [4:0]  b_fill;

    pixel_out_ctrl #(
        .PIXEL_W(8), .LINE_PIXELS(512), .NUM_LINES(512), .FIFO_DEPTH(1024)
    ) dut_a (
        .i_clk(clk), .i_rst(a_rst),
        .i_pixel_data(a_d), .i_pixel_data_valid(a_v),
        .o_line_credit(a_cred), .o_m_data(a_md), .o_m_valid(a_mv),
        .i_m_ready(a_rdy), .o_m_last(a_last), .o_m_sof(a_sof),
        .o_intr(a_intr), .o_overflow(a_ovf), .o_fill(a_fill)
    );

    pixel_out_ctrl #(
        .PIXEL_W(8), .LINE_PIXELS(8), .NUM_LINES(4), .FIFO_DEPTH(16)
    ) dut_b (
        .i_clk(clk), .i_rst(b_rst),
        .i_pixel_data(b_d), .i_pixel_data_valid(b_v),
        .o_line_credit(b_cred), .o_m_data(b_md), .o_m_valid(b_mv),
        .i_m_ready(b_rdy), .o_m_last(b_last), .o_m_sof(b_sof),
        .o_intr(b_intr), .o_overflow(b_ovf), .o_fill(b_fill)
    );

    exp_t q[2][$];
    int   pcnt[2];
    logic exp_intr[2];
    int   intr_cnt[2];
    int   sof_cnt[2];
    int   last_cnt[2];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic rnd_en = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push(input int k, input logic [7:0] d);
        int   lp, nl, px, ln;
        exp_t e;
        lp = (k == 1) ? 8 : 512;
        nl = (k == 1) ? 4 : 512;
        px = pcnt[k] % lp;
        ln = (pcnt[k] / lp) % nl;
        e.d    = d;
        e.last = (px == lp - 1);
        e.sof  = (px == 0) && (ln == 0);
        q[k].push_back(e);
        pcnt[k]++;
    endfunction

    task automatic mon(input int k, input logic rst, input logic v, input logic r,
                       input logic [7:0] d, input logic l, input logic s, input logic it);
        exp_t e;
        if (rst) begin
            exp_intr[k] = 1'b0;
        end else begin
            check($sformatf("intr%0d", k), it, exp_intr[k]);
            if (it) intr_cnt[k]++;
            exp_intr[k] = 1'b0;
            if (v) begin
                if (q[k].size() == 0) begin
                    check($sformatf("unexpected_out%0d", k), 1, 0);
                end else begin
                    e = q[k][0];
                    check($sformatf("data%0d", k), d, e.d);
                    check($sformatf("last%0d", k), l, e.last);
                    check($sformatf("sof%0d", k), s, e.sof);
                    if (r) begin
                        void'(q[k].pop_front());
                        exp_intr[k] = e.last;
                        if (s) sof_cnt[k]++;
                        if (l) last_cnt[k]++;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_rst, a_mv, a_rdy, a_md, a_last, a_sof, a_intr);
        mon(1, b_rst, b_mv, b_rdy, b_md, b_last, b_sof, b_intr);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) b_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cred(input int k, input int max);
        int n = 0;
        while (n < max && !((k == 1) ? b_cred : a_cred)) begin
            tick();
            n++;
        end
        check($sformatf("credit_wait%0d", k), (k == 1) ? b_cred : a_cred, 1);
    endtask

    task automatic wait_drain(input int k, input int max);
        int n = 0;
        while (n < max && q[k].size() != 0) begin
            tick();
            n++;
        end
        check($sformatf("drain%0d", k), q[k].size(), 0);
        repeat (3) tick();
    endtask

    task automatic send_a(input int n, input int base, input bit lat);
        for (int i = 0; i < n; i++) begin
            a_v = 1'b1;
            a_d = 8'((base + i) % 256);
            push(0, a_d);
            if (lat && i < 2) begin
                @(negedge clk);
                check("first_out_latency", a_mv, i);
                if (i == 1) check("credit_drop", a_cred, 0);
            end
            tick();
        end
        a_v = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n0;
        int n;
        a_rst = 1; b_rst = 1; a_v = 0; b_v = 0;
        a_d = 0; b_d = 0; a_rdy = 0; b_rdy = 0;
        for (int k = 0; k < 2; k++) begin
            pcnt[k] = 0; exp_intr[k] = 0; intr_cnt[k] = 0;
            sof_cnt[k] = 0; last_cnt[k] = 0;
        end

        // Reset held 5 cycles, all outputs low.
        repeat (5) begin
            tick();
            @(negedge clk);
            check("rst_credit", a_cred, 0);
            check("rst_valid", a_mv, 0);
            check("rst_last", a_last, 0);
            check("rst_sof", a_sof, 0);
            check("rst_intr", a_intr, 0);
            check("rst_ovf", a_ovf, 0);
            check("rst_fill", a_fill, 0);
            check("rst_b_valid", b_mv, 0);
        end
        tick();
        a_rst = 0;
        b_rst = 0;
        @(negedge clk);
        check("credit_cycle1", a_cred, 0);
        @(negedge clk);
        check("credit_cycle2", a_cred, 1);
        check("fill_after_rst", a_fill, 0);

        // Single line, free-flowing downstream.
        tick();
        a_rdy = 1;
        send_a(512, 0, 1);
        wait_drain(0, 200);
        check("s2_intr_count", intr_cnt[0], 1);
        check("s2_ovf", a_ovf, 0);
        check("s2_fill", a_fill, 0);

        // Two credited bursts into a stalled sink.
        a_rdy = 0;
        wait_cred(0, 10);
        send_a(512, 100, 0);
        check("s3_fill_512", a_fill, 512);
        wait_cred(0, 4);
        send_a(512, 17, 0);
        check("s3_fill_1024", a_fill, 1024);
        repeat (3) begin
            @(negedge clk);
            check("s3_credit_held", a_cred, 0);
            tick();
        end
        a_rdy = 1;
        n = 0;
        while (n < 1100 && !a_cred) begin
            @(negedge clk);
            n++;
        end
        check("s3_credit_return", a_cred, 1);
        check("s3_fill_at_credit", a_fill, 511);
        tick();
        wait_drain(0, 1200);
        check("s3_intr_count", intr_cnt[0], 3);

        // Credit ignored, FIFO overrun.
        a_rdy = 0;
        for (int i = 0; i < 1030; i++) begin
            a_v = 1;
            a_d = 8'(i % 256);
            if (i < 1024) push(0, a_d);
            if (i >= 1020) begin
                @(negedge clk);
                check($sformatf("s4_ovf_px%0d", i), a_ovf, (i > 1024));
            end
            tick();
        end
        a_v = 0;
        check("s4_fill_sat", a_fill, 1024);
        a_rdy = 1;
        wait_drain(0, 1200);
        check("s4_fill_empty", a_fill, 0);
        check("s4_intr_count", intr_cnt[0], 5);
        check("s4_ovf_sticky", a_ovf, 1);

        // Small instance: 5 lines, random backpressure.
        rnd_en = 1;
        for (int ln = 0; ln < 5; ln++) begin
            wait_cred(1, 100);
            for (int p = 0; p < 8; p++) begin
                b_v = 1;
                b_d = 8'(((ln * 8 + p) * 37 + 5) % 256);
                push(1, b_d);
                tick();
            end
            b_v = 0;
        end
        rnd_en = 0;
        tick();
        b_rdy = 1;
        wait_drain(1, 300);
        check("s5_intr_count", intr_cnt[1], 5);
        check("s5_sof_count", sof_cnt[1], 2);
        check("s5_last_count", last_cnt[1], 5);
        check("s5_ovf", b_ovf, 0);
        check("s5_fill", b_fill, 0);

        // Clean restart, then reset mid-burst while draining.
        a_rst = 1;
        q[0].delete();
        pcnt[0] = 0;
        tick();
        tick();
        check("s6_ovf_cleared", a_ovf, 0);
        a_rst = 0;
        wait_cred(0, 4);
        a_rdy = 0;
        send_a(100, 0, 0);
        a_rdy = 1;
        repeat (20) tick();
        check("s6_fill_mid_drain", a_fill, 80);
        a_rst = 1;
        q[0].delete();
        pcnt[0] = 0;
        tick();
        check("s6_rst_fill", a_fill, 0);
        check("s6_rst_valid", a_mv, 0);
        check("s6_rst_ovf", a_ovf, 0);
        check("s6_rst_credit", a_cred, 0);
        a_rst = 0;
        @(negedge clk);
        check("s6_credit_cycle1", a_cred, 0);
        @(negedge clk);
        check("s6_credit_cycle2", a_cred, 1);
        tick();
        n0 = intr_cnt[0];
        send_a(512, 0, 1);
        wait_drain(0, 200);
        check("s6_intr_count", intr_cnt[0] - n0, 1);
        check("s6_fill", a_fill, 0);
        check("s6_ovf", a_ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
